// File: rtl/gate_direction_decoder_pkg.sv
// Shared types and constants for the car-park gate direction decoder.
package gate_direction_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EN1,
    ST_EN2,
    ST_EN3,
    ST_EX1,
    ST_EX2,
    ST_EX3,
    ST_WAIT_CLR
  } state_e;

  // Filtered beam pattern {fa,fb}; a set bit means the beam is blocked.
  localparam logic [1:0] PAT_CLEAR = 2'b00;
  localparam logic [1:0] PAT_A     = 2'b10;
  localparam logic [1:0] PAT_BOTH  = 2'b11;
  localparam logic [1:0] PAT_B     = 2'b01;

  localparam int DEBOUNCE_DEFAULT = 4;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gate_direction_decoder_sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter for one beam sensor.
module sensor_debounce
  import gate_direction_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only survives while s2 keeps disagreeing with filt, so any
  // run shorter than DEBOUNCE_CYCLES is discarded.
  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/gate_direction_decoder.sv
// Turns two debounced gate beams into entry/exit/fault pulses via a sequence FSM.
module gate_direction_decoder
  import gate_direction_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic enter,
  output logic exit,
  output logic fault,
  output logic busy
);

  logic       fa, fb;
  logic [1:0] pat;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sensor_a),
    .filt (fa)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sensor_b),
    .filt (fb)
  );

  assign pat = {fa, fb};

  state_e state_q, state_d;
  logic   enter_q, enter_d;
  logic   exit_q, exit_d;
  logic   fault_q, fault_d;
  logic   busy_q, busy_d;
  logic   illegal;

  // Each state implies the pattern that led to it, so anything other than
  // "same", "one step forward" or "one step back" is illegal.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    fault_d = 1'b0;
    illegal = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (pat)
          PAT_CLEAR: ;
          PAT_A:     state_d = ST_EN1;
          PAT_B:     state_d = ST_EX1;
          default:   illegal = 1'b1;
        endcase
      end
      ST_EN1: begin
        case (pat)
          PAT_A:     ;
          PAT_BOTH:  state_d = ST_EN2;
          PAT_CLEAR: state_d = ST_IDLE;
          default:   illegal = 1'b1;
        endcase
      end
      ST_EN2: begin
        case (pat)
          PAT_BOTH:  ;
          PAT_B:     state_d = ST_EN3;
          PAT_A:     state_d = ST_EN1;
          default:   illegal = 1'b1;
        endcase
      end
      ST_EN3: begin
        case (pat)
          PAT_B:     ;
          PAT_CLEAR: begin
            state_d = ST_IDLE;
            enter_d = 1'b1;
          end
          PAT_BOTH:  state_d = ST_EN2;
          default:   illegal = 1'b1;
        endcase
      end
      ST_EX1: begin
        case (pat)
          PAT_B:     ;
          PAT_BOTH:  state_d = ST_EX2;
          PAT_CLEAR: state_d = ST_IDLE;
          default:   illegal = 1'b1;
        endcase
      end
      ST_EX2: begin
        case (pat)
          PAT_BOTH:  ;
          PAT_A:     state_d = ST_EX3;
          PAT_B:     state_d = ST_EX1;
          default:   illegal = 1'b1;
        endcase
      end
      ST_EX3: begin
        case (pat)
          PAT_A:     ;
          PAT_CLEAR: begin
            state_d = ST_IDLE;
            exit_d  = 1'b1;
          end
          PAT_BOTH:  state_d = ST_EX2;
          default:   illegal = 1'b1;
        endcase
      end
      ST_WAIT_CLR: begin
        if (pat == PAT_CLEAR) state_d = ST_IDLE;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      state_d = ST_WAIT_CLR;
      fault_d = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
    end
  end

  assign enter = enter_q;
  assign exit  = exit_q;
  assign fault = fault_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_gate_direction_decoder.sv
// Scoreboard bench: a sequence-position model predicts pulses and busy per edge.
module tb_gate_direction_decoder;

  localparam int DEB = 4;

  logic clk;
  logic rst_n;
  logic sensor_a;
  logic sensor_b;
  logic enter;
  logic exit;
  logic fault;
  logic busy;

  gate_direction_decoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .enter   (enter),
    .exit    (exit),
    .fault   (fault),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [2:0] kind;  // {enter, exit, fault}
  } evt_t;
  evt_t exp_q[$];

  // Reference model: raw sample history, filtered bits, and position along
  // the entry or exit beam sequence.
  logic [1:0] hist[$];
  logic       mfa, mfb;
  int         dir;   // 1 = entry, 2 = exit
  int         pos;   // 0 = idle, 1..3 = step reached
  bit         wclr;
  bit         mbusy;

  function automatic logic [1:0] seq_pat(input int d, input int idx);
    logic [1:0] ent[4];
    logic [1:0] ext[4];
    ent = '{2'b00, 2'b10, 2'b11, 2'b01};
    ext = '{2'b00, 2'b01, 2'b11, 2'b10};
    return (d == 1) ? ent[idx] : ext[idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back(2'b00);
      mfa = 1'b0; mfb = 1'b0;
      dir = 0; pos = 0; wclr = 0; mbusy = 0;
    end else begin
      logic [1:0] p, cur;
      logic [2:0] kind;
      bit da, db, bad;
      int n;
      cyc++;
      p = {mfa, mfb};
      kind = 3'b000;
      bad = 0;
      if (wclr) begin
        if (p == 2'b00) wclr = 0;
      end else begin
        cur = (pos == 0) ? 2'b00 : seq_pat(dir, pos);
        if (p == cur) begin
        end else if (pos == 0) begin
          if (p == 2'b10) begin dir = 1; pos = 1; end
          else if (p == 2'b01) begin dir = 2; pos = 1; end
          else bad = 1;
        end else if (pos < 3 && p == seq_pat(dir, pos + 1)) begin
          pos++;
        end else if (pos == 3 && p == 2'b00) begin
          kind = (dir == 1) ? 3'b100 : 3'b010;
          pos = 0;
        end else if (p == seq_pat(dir, pos - 1)) begin
          pos--;
        end else begin
          bad = 1;
        end
        if (bad) begin
          wclr = 1; pos = 0; kind = 3'b001;
        end
      end
      if (kind != 3'b000) exp_q.push_back('{cyc, kind});
      mbusy = wclr || (pos != 0);

      hist.push_back({sensor_a, sensor_b});
      if (hist.size() > DEB + 3) void'(hist.pop_front());
      n = hist.size();
      da = 1; db = 1;
      for (int i = 0; i < DEB; i++) begin
        if (hist[n-3-i][1] == mfa) da = 0;
        if (hist[n-3-i][0] == mfb) db = 0;
      end
      if (da) mfa = ~mfa;
      if (db) mfb = ~mfb;
    end
  end

  // Monitor: busy every cycle, and a scoreboard pop for every DUT pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (busy !== mbusy) begin
        errors++;
        $display("FAIL busy at cycle %0d: got %b expected %b", cyc, busy, mbusy);
      end
      if ((enter | exit | fault) !== 1'b0) begin
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse at cycle %0d: got {enter,exit,fault}=%b expected none",
                   cyc, {enter, exit, fault});
        end else begin
          e = exp_q.pop_front();
          if ({enter, exit, fault} !== e.kind || cyc != e.cyc) begin
            errors++;
            $display("FAIL pulse at cycle %0d: got %b expected %b at cycle %0d",
                     cyc, {enter, exit, fault}, e.kind, e.cyc);
          end
        end
      end
    end
  end

  task automatic drive(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    #2 rst_n = 1'b0;
    sensor_a = a;
    sensor_b = b;
    #1;
    checks++;
    if ({enter, exit, fault, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got {enter,exit,fault,busy}=%b expected 0000",
               {enter, exit, fault, busy});
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int kc;
    bit seen;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({enter, exit, fault, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL initial_reset: got {enter,exit,fault,busy}=%b expected 0000",
               {enter, exit, fault, busy});
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    drive(0, 0, 5);

    // Clean entry with an explicit latency check on the final clear.
    drive(1, 0, 10);
    drive(1, 1, 10);
    drive(0, 1, 10);
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    kc = cyc + 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (enter === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || cyc != kc + DEB + 2) begin
      errors++;
      $display("FAIL entry_latency: got enter seen=%0d at edge %0d expected edge %0d",
               seen, cyc, kc + DEB + 2);
    end
    drive(0, 0, 10);

    // Clean exit.
    drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 15);

    // Glitches: 3-cycle ignored, 4-cycle accepted then released.
    drive(1, 0, 3); drive(0, 0, 15);
    drive(1, 0, 4); drive(0, 0, 15);

    // Reversal.
    drive(1, 0, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 15);

    // Illegal simultaneous block, then clear.
    drive(1, 1, 10); drive(0, 0, 15);

    // Reset while in EN3, then a full entry.
    drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10);
    do_reset(0, 0);
    drive(0, 0, 15);
    drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10); drive(0, 0, 15);

    // Sensors already blocked when reset releases.
    do_reset(1, 0);
    drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10); drive(0, 0, 15);
    do_reset(1, 1);
    drive(1, 1, 10); drive(0, 0, 15);

    // Random walk with random hold lengths, including short glitches.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    drive(0, 0, 20);
    // Random legal walks along the entry/exit paths.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(1, 0, $urandom_range(5, 9)); drive(1, 1, $urandom_range(5, 9));
        drive(0, 1, $urandom_range(5, 9));
      end else begin
        drive(0, 1, $urandom_range(5, 9)); drive(1, 1, $urandom_range(5, 9));
        drive(1, 0, $urandom_range(5, 9));
      end
      drive(0, 0, 12);
    end
    drive(0, 0, 20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d unconsumed expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
